// File: rtl/edge_class_buffer_if.sv
// rtl/edge_class_buffer_if.sv - control, gradient and class-stream bundle for edge_class_buffer
// strongCount exists only when EDGE_STRONG_COUNT_EN is defined.
interface edge_class_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
);
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic              buffClr;
  logic              enb;
  logic              buffMode;
  logic [DATA_W-1:0] upDownArray;
  logic [DATA_W-1:0] leftRightArray;
  logic [DATA_W:0]   thrLo;
  logic [DATA_W:0]   thrHi;
  logic [1:0]        outClass;
  logic              outValid;
  logic              complete;
  logic              overflow;
  logic [PTR_W-1:0]  pixCount;
`ifdef EDGE_STRONG_COUNT_EN
  logic [PTR_W-1:0]  strongCount;
`endif

  modport master (
    output buffClr, enb, buffMode, upDownArray, leftRightArray, thrLo, thrHi,
`ifdef EDGE_STRONG_COUNT_EN
    input  strongCount,
`endif
    input  outClass, outValid, complete, overflow, pixCount
  );

  modport slave (
    input  buffClr, enb, buffMode, upDownArray, leftRightArray, thrLo, thrHi,
`ifdef EDGE_STRONG_COUNT_EN
    output strongCount,
`endif
    output outClass, outValid, complete, overflow, pixCount
  );
endinterface

// File: rtl/edge_class_buffer.sv
// rtl/edge_class_buffer.sv - classifies UD+LR gradient magnitude, buffers classes, streams them on command
// Optional EDGE_STRONG_COUNT_EN adds a count of strong pixels written during load.
module edge_class_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input logic clk,
  input logic reset,
  edge_class_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, FULL, SEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [1:0]       outClass_q, outClass_d;
  logic             outValid_q, outValid_d;
  logic             complete_q, complete_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] strongCount_q, strongCount_d;
  logic [DATA_W:0]  mag;
  logic [1:0]       in_class;
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       mem [DEPTH];

  always_comb begin
    mag = {1'b0, bus.upDownArray} + {1'b0, bus.leftRightArray};
    // strong is tested first so it wins when thrLo > thrHi
    if (mag >= bus.thrHi)
      in_class = 2'd2;
    else if (mag >= bus.thrLo)
      in_class = 2'd1;
    else
      in_class = 2'd0;
  end

  always_comb begin
    state_d       = state_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    overflow_d    = overflow_q;
    strongCount_d = strongCount_q;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (bus.enb) begin
          if (!bus.buffMode)
            wr_en = 1'b1;
          else if (wrPtr_q == '0)
            state_d = DONE;
          else begin
            rd_en   = 1'b1;
            state_d = SEND;
          end
        end
      end
      FULL: begin
        if (bus.enb) begin
          if (!bus.buffMode)
            overflow_d = 1'b1;
          else begin
            rd_en   = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND:    rd_en = bus.enb;
      DONE:    ;
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      wrPtr_d = wrPtr_q + 1'b1;
      state_d = (wrPtr_d == PTR_W'(DEPTH)) ? FULL : LOAD;
      if (in_class == 2'd2)
        strongCount_d = strongCount_q + 1'b1;
    end
    // the entry cycle into SEND already performs the first read
    if (rd_en) begin
      rdPtr_d = rdPtr_q + 1'b1;
      if (rdPtr_d == wrPtr_q)
        state_d = DONE;
    end

    outValid_d = rd_en;
    outClass_d = rd_en ? mem[rdPtr_q[ADDR_W-1:0]] : 2'd0;
    complete_d = complete_q | (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wrPtr_q[ADDR_W-1:0]] <= in_class;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.buffClr) begin
      state_q       <= IDLE;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      outClass_q    <= 2'd0;
      outValid_q    <= 1'b0;
      complete_q    <= 1'b0;
      overflow_q    <= 1'b0;
      strongCount_q <= '0;
    end else begin
      state_q       <= state_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      outClass_q    <= outClass_d;
      outValid_q    <= outValid_d;
      complete_q    <= complete_d;
      overflow_q    <= overflow_d;
      strongCount_q <= strongCount_d;
    end
  end

  assign bus.outClass = outClass_q;
  assign bus.outValid = outValid_q;
  assign bus.complete = complete_q;
  assign bus.overflow = overflow_q;
  assign bus.pixCount = wrPtr_q;
`ifdef EDGE_STRONG_COUNT_EN
  assign bus.strongCount = strongCount_q;
`else
  logic unused_strong;
  assign unused_strong = ^strongCount_q;
`endif
endmodule
